// File: rtl/obj_nav_pkg.sv
// Shared types and defaults for the obstacle maneuver sequencer.
// Holds the state encoding, the turn direction type, the output bundle and its decoder.
package obj_nav_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CRUISE  = 3'd1,
        S_STOP    = 3'd2,
        S_REVERSE = 3'd3,
        S_TURN_L  = 3'd4,
        S_TURN_R  = 3'd5
    } state_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    typedef struct packed {
        logic fwd;
        logic rev;
        logic left;
        logic right;
        logic busy;
    } drive_t;

    localparam int unsigned DEF_DEB_CYCLES  = 4;
    localparam int unsigned DEF_STOP_CYCLES = 8;
    localparam int unsigned DEF_REV_CYCLES  = 16;
    localparam int unsigned DEF_TURN_CYCLES = 24;
    localparam int unsigned DEF_CNT_W       = 8;

    // Motor/steer/busy pattern owned by each state.
    function automatic drive_t decode(state_t s);
        drive_t d;
        d = '0;
        case (s)
            S_CRUISE:  d.fwd = 1'b1;
            S_STOP:    d.busy = 1'b1;
            S_REVERSE: begin
                d.rev  = 1'b1;
                d.busy = 1'b1;
            end
            S_TURN_L:  begin
                d.fwd  = 1'b1;
                d.left = 1'b1;
                d.busy = 1'b1;
            end
            S_TURN_R:  begin
                d.fwd   = 1'b1;
                d.right = 1'b1;
                d.busy  = 1'b1;
            end
            default:   d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/obj_nav_ctrl_if.sv
// Command/status bundle between the supervisor and the maneuver sequencer.
// Inputs: enable and raw obstacle flags; outputs: motor/steer commands, busy, done pulse, state.
interface obj_nav_ctrl_if;

    logic       enable;
    logic       left_object;
    logic       right_object;
    logic       front_object;
    logic       motor_fwd;
    logic       motor_rev;
    logic       turn_left;
    logic       turn_right;
    logic       busy;
    logic       maneuver_done;
    logic [2:0] state_o;

    modport master (
        output enable, left_object, right_object, front_object,
        input  motor_fwd, motor_rev, turn_left, turn_right,
        input  busy, maneuver_done, state_o
    );

    modport slave (
        input  enable, left_object, right_object, front_object,
        output motor_fwd, motor_rev, turn_left, turn_right,
        output busy, maneuver_done, state_o
    );

endinterface

// File: rtl/obj_debounce.sv
// Single-flag debouncer: output toggles after DEB_CYCLES consecutive differing samples.
// Ports: clk, reset (sync, active-low), din raw flag, dout filtered flag.
module obj_debounce #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;

    // An agreeing sample leaves cnt_d at zero, restarting the run.
    always_comb begin
        cnt_d  = '0;
        dout_d = dout_q;
        if (din != dout_q) begin
            if (cnt_q == LAST) begin
                dout_d = ~dout_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= '0;
            dout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/obj_nav_ctrl.sv
// Timed Moore sequencer: cruise, stop, reverse, then turn away from debounced obstacles.
// Ports: clk, reset (sync, active-low), bus (slave modport of obj_nav_ctrl_if).
module obj_nav_ctrl
    import obj_nav_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int unsigned STOP_CYCLES = DEF_STOP_CYCLES,
    parameter int unsigned REV_CYCLES  = DEF_REV_CYCLES,
    parameter int unsigned TURN_CYCLES = DEF_TURN_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input logic            clk,
    input logic            reset,
    obj_nav_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CYCLES - 1);
    localparam logic [CNT_W-1:0] REV_LAST  = CNT_W'(REV_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYCLES - 1);

    logic f_left, f_right, f_front;

    obj_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_l (
        .clk(clk), .reset(reset), .din(bus.left_object), .dout(f_left)
    );
    obj_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_r (
        .clk(clk), .reset(reset), .din(bus.right_object), .dout(f_right)
    );
    obj_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_f (
        .clk(clk), .reset(reset), .din(bus.front_object), .dout(f_front)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    dir_t             dir_q, dir_d;
    drive_t           drv_q;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        if (!bus.enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   state_d = S_CRUISE;
                S_CRUISE: begin
                    if (f_left || f_right || f_front) state_d = S_STOP;
                end
                S_STOP: begin
                    if (timer_q == STOP_LAST) begin
                        if (f_front || (f_left && f_right)) begin
                            state_d = S_REVERSE;
                            // Only a lone right obstacle favours a left escape.
                            dir_d = (f_right && !f_left) ? DIR_LEFT : DIR_RIGHT;
                        end else if (f_left) begin
                            state_d = S_TURN_R;
                        end else if (f_right) begin
                            state_d = S_TURN_L;
                        end else begin
                            state_d = S_CRUISE;
                        end
                    end
                end
                S_REVERSE: begin
                    if (timer_q == REV_LAST) begin
                        state_d = (dir_q == DIR_LEFT) ? S_TURN_L : S_TURN_R;
                    end
                end
                S_TURN_L, S_TURN_R: begin
                    if (timer_q == TURN_LAST) begin
                        if (f_front) begin
                            state_d = S_STOP;
                        end else begin
                            state_d = S_CRUISE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Timer restarts on every state change and only runs in timed states.
    always_comb begin
        timer_d = '0;
        if (state_d == state_q && decode(state_q).busy) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Outputs are registered from the next state so they track state_q exactly.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            dir_q   <= DIR_LEFT;
            drv_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            dir_q   <= dir_d;
            drv_q   <= decode(state_d);
            done_q  <= done_d;
        end
    end

    assign bus.motor_fwd     = drv_q.fwd;
    assign bus.motor_rev     = drv_q.rev;
    assign bus.turn_left     = drv_q.left;
    assign bus.turn_right    = drv_q.right;
    assign bus.busy          = drv_q.busy;
    assign bus.maneuver_done = done_q;
    assign bus.state_o       = state_q;

endmodule

// File: tb/tb_obj_nav_ctrl.sv
// Directed bench for obj_nav_ctrl with default timing parameters.
// Each scenario task drives the raw flags and checks state, outputs and durations.
module tb_obj_nav_ctrl;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   done_cnt;

    obj_nav_ctrl_if bus ();

    obj_nav_ctrl #(
        .DEB_CYCLES(4), .STOP_CYCLES(8), .REV_CYCLES(16),
        .TURN_CYCLES(24), .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [5:0] outs();
        return {bus.motor_fwd, bus.motor_rev, bus.turn_left,
                bus.turn_right, bus.busy, bus.maneuver_done};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (bus.maneuver_done === 1'b1) done_cnt++;
    endtask

    task automatic run_len(input logic [2:0] st, output int n);
        n = 0;
        while (bus.state_o === st && n < 200) begin
            n++;
            step();
        end
    endtask

    task automatic wait_state(input logic [2:0] st, output int n);
        n = 0;
        while (bus.state_o !== st && n < 50) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.enable = 1'b0;
        bus.left_object = 1'b0;
        bus.right_object = 1'b0;
        bus.front_object = 1'b0;
        step();
        step();
        checks++;
        if (outs() !== 6'b0) begin
            $display("FAIL reset_outs: got %b want 000000", outs());
            errors++;
        end
        checks++;
        if (bus.state_o !== 3'd0) begin
            $display("FAIL reset_state: got %0d want 0", bus.state_o);
            errors++;
        end
        done_cnt = 0;
        reset = 1'b1;
        bus.enable = 1'b1;
        step();
        checks++;
        if (bus.state_o !== 3'd1 || outs() !== 6'b100000) begin
            $display("FAIL enable_cruise: state %0d outs %b want 1 100000",
                     bus.state_o, outs());
            errors++;
        end
    endtask

    task automatic test_glitch();
        int n;
        bus.left_object = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.busy !== 1'b0 || bus.state_o !== 3'd1) begin
                $display("FAIL glitch3_cyc%0d: busy %b state %0d want 0 1",
                         i, bus.busy, bus.state_o);
                errors++;
            end
        end
        bus.left_object = 1'b0;
        repeat (6) step();
        checks++;
        if (bus.state_o !== 3'd1) begin
            $display("FAIL glitch3_after: state %0d want 1", bus.state_o);
            errors++;
        end
        bus.left_object = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (bus.motor_fwd !== 1'b1) begin
                $display("FAIL deb4_fwd_cyc%0d: got %b want 1", i, bus.motor_fwd);
                errors++;
            end
        end
        bus.left_object = 1'b0;
        step();
        checks++;
        if (bus.motor_fwd !== 1'b0 || bus.state_o !== 3'd2) begin
            $display("FAIL deb4_stop: fwd %b state %0d want 0 2",
                     bus.motor_fwd, bus.state_o);
            errors++;
        end
        run_len(3'd2, n);
        checks++;
        if (n !== 8) begin
            $display("FAIL deb4_stop_len: got %0d want 8", n);
            errors++;
        end
        checks++;
        if (bus.state_o !== 3'd1 || done_cnt !== 0) begin
            $display("FAIL deb4_resume: state %0d done %0d want 1 0",
                     bus.state_o, done_cnt);
            errors++;
        end
    endtask

    task automatic test_front();
        int n;
        int d0;
        d0 = done_cnt;
        bus.front_object = 1'b1;
        wait_state(3'd2, n);
        checks++;
        if (n !== 5) begin
            $display("FAIL front_latency: got %0d want 5", n);
            errors++;
        end
        run_len(3'd2, n);
        checks++;
        if (n !== 8) begin
            $display("FAIL front_stop_len: got %0d want 8", n);
            errors++;
        end
        checks++;
        if (bus.state_o !== 3'd3 || outs() !== 6'b010010) begin
            $display("FAIL front_rev: state %0d outs %b want 3 010010",
                     bus.state_o, outs());
            errors++;
        end
        bus.front_object = 1'b0;
        run_len(3'd3, n);
        checks++;
        if (n !== 16) begin
            $display("FAIL front_rev_len: got %0d want 16", n);
            errors++;
        end
        checks++;
        if (bus.state_o !== 3'd5 || outs() !== 6'b100110) begin
            $display("FAIL front_turn_r: state %0d outs %b want 5 100110",
                     bus.state_o, outs());
            errors++;
        end
        run_len(3'd5, n);
        checks++;
        if (n !== 24) begin
            $display("FAIL front_turn_len: got %0d want 24", n);
            errors++;
        end
        checks++;
        if (bus.state_o !== 3'd1 || bus.maneuver_done !== 1'b1) begin
            $display("FAIL front_done: state %0d done %b want 1 1",
                     bus.state_o, bus.maneuver_done);
            errors++;
        end
        step();
        checks++;
        if (bus.maneuver_done !== 1'b0 || done_cnt - d0 !== 1) begin
            $display("FAIL front_done_pulse: done %b pulses %0d want 0 1",
                     bus.maneuver_done, done_cnt - d0);
            errors++;
        end
    endtask

    task automatic test_front_right();
        int n;
        int d0;
        d0 = done_cnt;
        bus.front_object = 1'b1;
        bus.right_object = 1'b1;
        wait_state(3'd2, n);
        run_len(3'd2, n);
        checks++;
        if (n !== 8 || bus.state_o !== 3'd3) begin
            $display("FAIL fr_stop: len %0d state %0d want 8 3", n, bus.state_o);
            errors++;
        end
        run_len(3'd3, n);
        checks++;
        if (bus.state_o !== 3'd4 || outs() !== 6'b101010) begin
            $display("FAIL fr_turn_l: state %0d outs %b want 4 101010",
                     bus.state_o, outs());
            errors++;
        end
        run_len(3'd4, n);
        checks++;
        if (n !== 24 || bus.state_o !== 3'd2 || bus.maneuver_done !== 1'b0) begin
            $display("FAIL fr_restop: len %0d state %0d done %b want 24 2 0",
                     n, bus.state_o, bus.maneuver_done);
            errors++;
        end
        bus.front_object = 1'b0;
        bus.right_object = 1'b0;
        run_len(3'd2, n);
        checks++;
        if (n !== 8 || bus.state_o !== 3'd1 || done_cnt !== d0) begin
            $display("FAIL fr_clear: len %0d state %0d pulses %0d want 8 1 0",
                     n, bus.state_o, done_cnt - d0);
            errors++;
        end
    endtask

    task automatic test_right_short();
        int n;
        int d0;
        d0 = done_cnt;
        bus.right_object = 1'b1;
        repeat (5) step();
        checks++;
        if (bus.state_o !== 3'd2) begin
            $display("FAIL rs_stop: state %0d want 2", bus.state_o);
            errors++;
        end
        step();
        bus.right_object = 1'b0;
        run_len(3'd2, n);
        checks++;
        if (n !== 7) begin
            $display("FAIL rs_stop_rest: got %0d want 7", n);
            errors++;
        end
        checks++;
        if (bus.state_o !== 3'd1 || outs() !== 6'b100000 || done_cnt !== d0) begin
            $display("FAIL rs_cruise: state %0d outs %b pulses %0d want 1 100000 0",
                     bus.state_o, outs(), done_cnt - d0);
            errors++;
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int d0;
        d0 = done_cnt;
        bus.front_object = 1'b1;
        wait_state(3'd2, n);
        run_len(3'd2, n);
        bus.front_object = 1'b0;
        repeat (4) step();
        checks++;
        if (bus.state_o !== 3'd3) begin
            $display("FAIL rm_in_rev: state %0d want 3", bus.state_o);
            errors++;
        end
        reset = 1'b0;
        step();
        checks++;
        if (outs() !== 6'b0 || bus.state_o !== 3'd0) begin
            $display("FAIL rm_abort: outs %b state %0d want 000000 0",
                     outs(), bus.state_o);
            errors++;
        end
        reset = 1'b1;
        step();
        checks++;
        if (bus.state_o !== 3'd1 || bus.motor_fwd !== 1'b1) begin
            $display("FAIL rm_resume: state %0d fwd %b want 1 1",
                     bus.state_o, bus.motor_fwd);
            errors++;
        end
        repeat (40) step();
        checks++;
        if (bus.state_o !== 3'd1 || done_cnt !== d0) begin
            $display("FAIL rm_no_done: state %0d pulses %0d want 1 0",
                     bus.state_o, done_cnt - d0);
            errors++;
        end
    endtask

    task automatic test_enable();
        bus.enable = 1'b0;
        step();
        checks++;
        if (bus.state_o !== 3'd0 || outs() !== 6'b0) begin
            $display("FAIL en_low: state %0d outs %b want 0 000000",
                     bus.state_o, outs());
            errors++;
        end
        bus.enable = 1'b1;
        step();
        checks++;
        if (bus.state_o !== 3'd1 || outs() !== 6'b100000) begin
            $display("FAIL en_high: state %0d outs %b want 1 100000",
                     bus.state_o, outs());
            errors++;
        end
    endtask

    task automatic test_enable_vs_timer();
        int n;
        bus.right_object = 1'b1;
        wait_state(3'd2, n);
        repeat (7) step();
        checks++;
        if (bus.state_o !== 3'd2) begin
            $display("FAIL evt_last_stop: state %0d want 2", bus.state_o);
            errors++;
        end
        bus.enable = 1'b0;
        step();
        checks++;
        if (bus.state_o !== 3'd0 || outs() !== 6'b0) begin
            $display("FAIL evt_idle_wins: state %0d outs %b want 0 000000",
                     bus.state_o, outs());
            errors++;
        end
        bus.right_object = 1'b0;
        repeat (6) step();
        bus.enable = 1'b1;
        step();
        checks++;
        if (bus.state_o !== 3'd1) begin
            $display("FAIL evt_recover: state %0d want 1", bus.state_o);
            errors++;
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        done_cnt = 0;
        test_reset();
        test_glitch();
        test_front();
        test_front_right();
        test_right_short();
        test_reset_mid();
        test_enable();
        test_enable_vs_timer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/obj_nav_ctrl.md
# obj_nav_ctrl

Maneuver sequencer that sits downstream of the obstacle-detection FSM. It consumes the `left_object`, `right_object` and `front_object` flags and debounces each one. A timed Moore state machine then drives drive-motor and steering commands: cruise, stop, reverse, then turn away from the obstacle. It is the only block that owns the motor/steer outputs.

## Interface
- `DEB_CYCLES`, default 4: consecutive samples required before a filtered flag changes.
- `STOP_CYCLES`, default 8: length of the STOP state in cycles.
- `REV_CYCLES`, default 16: length of the REVERSE state in cycles.
- `TURN_CYCLES`, default 24: length of the TURN_L / TURN_R state in cycles.
- `CNT_W`, default 8: timer and debounce counter width. All cycle parameters must be ≥1 and ≤2^CNT_W−1.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `enable`  in  1  run request; low forces IDLE.
- `left_object`  in  1  raw left-obstacle flag.
- `right_object`  in  1  raw right-obstacle flag.
- `front_object`  in  1  raw front-obstacle flag.
- `motor_fwd`  out  1  drive forward.
- `motor_rev`  out  1  drive reverse.
- `turn_left`  out  1  steer left.
- `turn_right`  out  1  steer right.
- `busy`  out  1  high in STOP, REVERSE, TURN_L and TURN_R.
- `maneuver_done`  out  1  one-cycle pulse on TURN → CRUISE exit.
- `state_o`  out  3  current state encoding, for debug.

## Operation
- Debounce, per channel:
  - The filtered flag `f_*` toggles on the edge where the DEB_CYCLES-th consecutive raw sample differing from `f_*` is taken.
  - Any agreeing sample clears that channel's counter.
- States:
  - IDLE: all outputs 0.
  - CRUISE: `motor_fwd`=1.
  - STOP: all motors 0.
  - REVERSE: `motor_rev`=1.
  - TURN_L: `motor_fwd`=1, `turn_left`=1.
  - TURN_R: `motor_fwd`=1, `turn_right`=1.
  - All outputs decode only from the state register; at most one motor bit and one steer bit are high.
- Transitions. `enable`=0 is checked first from every state.
  - Any state with `enable`=0 → IDLE.
  - IDLE with `enable`=1 → CRUISE.
  - CRUISE with any `f_*`=1 → STOP.
  - STOP at timer end, decision taken from the `f_*` values on that cycle:
    - none set → CRUISE, with no `maneuver_done`.
    - `f_front`, or `f_left`&`f_right` → REVERSE. Latch `dir_q` = LEFT if `f_right`&!`f_left`, otherwise RIGHT.
    - `f_left` only → TURN_R.
    - `f_right` only → TURN_L.
  - REVERSE at timer end → TURN_L or TURN_R per `dir_q`.
  - TURN at timer end → STOP if `f_front`=1 (re-evaluate). Otherwise → CRUISE and pulse `maneuver_done`.
- Timer: cleared on every state entry. The state exits on the cycle the timer equals N−1, so each timed state lasts exactly N cycles.
- `f_*` changes during STOP, REVERSE or TURN do not alter the sequence. They are only sampled at the decision points listed above.

## Timing
- Reset (`reset`=0 at an edge):
  - state = IDLE.
  - All counters, `f_*` and `dir_q` = 0.
  - All outputs = 0 from the following cycle.
- Reset mid-maneuver aborts the maneuver immediately; there is no `maneuver_done` pulse.
- Detection latency: raw high first sampled at edge e0 → `f_*` high after edge e0+DEB−1 → state STOP after edge e0+DEB.
  - So `motor_fwd` falls DEB cycles after the first high sample.
- A raw pulse shorter than DEB cycles has no effect.
- Release: `f_*` clears DEB cycles after raw goes low.
- `enable` falling: IDLE, with all outputs 0, one cycle later. `enable` rising: CRUISE one cycle later.
- Simultaneous `enable`=0 and a timer end: IDLE wins.

## Structure
- Package `obj_nav_pkg`:
  - State encoding: IDLE=0, CRUISE=1, STOP=2, REVERSE=3, TURN_L=4, TURN_R=5.
  - `dir_t` (LEFT/RIGHT).
  - Default parameter constants.
- Sub-module `obj_debounce`:
  - Parameters DEB_CYCLES and CNT_W.
  - Ports: `clk`, `reset`, `din`, `dout`.
  - Instantiated three times.
- Top level holds the FSM, the shared maneuver timer and `dir_q`.

## Test plan
- Run with defaults. Reset low for 2 cycles, then `enable`=1: all outputs 0 during reset, `motor_fwd`=1 one cycle after enable.
- Glitch rejection:
  - `left_object` high for 3 cycles: stays CRUISE, `busy`=0.
  - High for 4 cycles: STOP entered, `motor_fwd`=0 exactly 4 cycles after the first high sample.
- `front_object` held high through STOP, then released:
  - STOP for 8 cycles, `motor_rev` for 16, `turn_right` for 24.
  - Since `f_front` has cleared, TURN exits to CRUISE with a single `maneuver_done` pulse.
- `front_object`+`right_object` held high:
  - REVERSE, then TURN_L.
  - `front` still high at TURN end → STOP again, with no `maneuver_done`.
- `right_object` alone for 6 cycles, then released before STOP ends: STOP for 8 cycles → CRUISE, no turn, no `maneuver_done`.
- Reset low at cycle 5 of REVERSE:
  - Next cycle all outputs 0 and `state_o`=0.
  - After release with `enable`=1, CRUISE resumes and `maneuver_done` never pulses.
